// File: rtl/pipe_hazard_unit.sv
// rtl/pipe_hazard_unit.sv - hazard detection and operand forwarding for the in-order pipeline
//
// Tracks in-flight register writers in a DEPTH-entry scoreboard that shifts
// one stage per clock (entry 0 = EX, 1 = MEM, 2 = WB, ...). Looks up the
// instruction in ID against that scoreboard to produce the load-use stall and
// the registered forwarding selects that apply once it reaches EX.
//
// Optional build macro: HAZARD_STATS_EN adds stall_cnt / fwd_cnt counters.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   issue_valid                instruction present in ID
//   issue_rs, issue_rt         source register indices
//   issue_use_rs, issue_use_rt source actually read
//   issue_wr_en, issue_wr_reg  destination write enable / index
//   issue_is_load              destination comes from a memory read
//   flush                      kill the instruction in ID
//   stall                      combinational: hold PC and IF/ID, inject bubble
//   fwd_a, fwd_b               registered EX operand source (0 = regfile, k = stage k)
//   stage_valid                registered scoreboard occupancy
//   stall_cnt, fwd_cnt         (HAZARD_STATS_EN only) saturating event counters

module pipe_hazard_unit #(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int FW         = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rs,
  input  logic [REG_AW-1:0] issue_rt,
  input  logic              issue_use_rs,
  input  logic              issue_use_rt,
  input  logic              issue_wr_en,
  input  logic [REG_AW-1:0] issue_wr_reg,
  input  logic              issue_is_load,
  input  logic              flush,
  output logic              stall,
  output logic [FW-1:0]     fwd_a,
  output logic [FW-1:0]     fwd_b,
`ifdef HAZARD_STATS_EN
  output logic [31:0]       stall_cnt,
  output logic [31:0]       fwd_cnt,
`endif
  output logic [DEPTH-1:0]  stage_valid
);

  // Valid bits cover every tracked stage. The write/destination/load fields
  // are only kept for entries 0..DEPTH-2: the oldest entry has already
  // committed to the register file by the time a reader reaches EX, so its
  // fields can never influence a lookup.
  logic [DEPTH-1:0]  sb_v;
  logic [DEPTH-2:0]  sb_wr;
  logic [DEPTH-2:0]  sb_ld;
  logic [REG_AW-1:0] sb_rd [DEPTH-1];

  logic [FW-1:0] sel_a;
  logic [FW-1:0] sel_b;
  logic          hz_a;
  logic          hz_b;
  logic          accept;

  assign stage_valid = sb_v;

  // Scan oldest to youngest so the youngest matching producer overwrites
  // any older one. Register 0 never matches.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    hz_a  = 1'b0;
    hz_b  = 1'b0;
    for (int j = DEPTH - 2; j >= 0; j--) begin
      if (issue_use_rs && sb_v[j] && sb_wr[j] &&
          (sb_rd[j] == issue_rs) && (issue_rs != '0)) begin
        sel_a = FW'(j + 1);
        hz_a  = sb_ld[j] && ((j + 1) < LOAD_STAGE);
      end
      if (issue_use_rt && sb_v[j] && sb_wr[j] &&
          (sb_rd[j] == issue_rt) && (issue_rt != '0)) begin
        sel_b = FW'(j + 1);
        hz_b  = sb_ld[j] && ((j + 1) < LOAD_STAGE);
      end
    end
  end

  // flush wins over stall; reset forces the stall low immediately.
  assign stall  = ~rst & issue_valid & ~flush & (hz_a | hz_b);
  assign accept = issue_valid & ~stall & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_v  <= '0;
      sb_wr <= '0;
      sb_ld <= '0;
      for (int j = 0; j < DEPTH - 1; j++) sb_rd[j] <= '0;
      fwd_a <= '0;
      fwd_b <= '0;
    end else begin
      sb_v <= {sb_v[DEPTH-2:0], accept};
      for (int j = DEPTH - 2; j >= 1; j--) begin
        sb_wr[j] <= sb_wr[j-1];
        sb_ld[j] <= sb_ld[j-1];
        sb_rd[j] <= sb_rd[j-1];
      end
      // A stalled, flushed or absent instruction enters as an all-zero bubble.
      sb_wr[0] <= accept & issue_wr_en;
      sb_ld[0] <= accept & issue_is_load;
      sb_rd[0] <= accept ? issue_wr_reg : '0;
      fwd_a    <= accept ? sel_a : '0;
      fwd_b    <= accept ? sel_b : '0;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (accept && ((sel_a != '0) || (sel_b != '0)) && (fwd_cnt != '1))
        fwd_cnt <= fwd_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb/tb_pipe_hazard_unit.sv - directed self-checking bench for pipe_hazard_unit
module tb_pipe_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid;
  logic [4:0] issue_rs;
  logic [4:0] issue_rt;
  logic       issue_use_rs;
  logic       issue_use_rt;
  logic       issue_wr_en;
  logic [4:0] issue_wr_reg;
  logic       issue_is_load;
  logic       flush;
  logic       stall;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic [2:0] stage_valid;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] fwd_cnt;
`endif

  int total = 0;
  int bad   = 0;

  pipe_hazard_unit dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_rs      (issue_rs),
    .issue_rt      (issue_rt),
    .issue_use_rs  (issue_use_rs),
    .issue_use_rt  (issue_use_rt),
    .issue_wr_en   (issue_wr_en),
    .issue_wr_reg  (issue_wr_reg),
    .issue_is_load (issue_is_load),
    .flush         (flush),
    .stall         (stall),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b),
`ifdef HAZARD_STATS_EN
    .stall_cnt     (stall_cnt),
    .fwd_cnt       (fwd_cnt),
`endif
    .stage_valid   (stage_valid)
  );

  always #5 clk = ~clk;

  task automatic drv(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt, input logic wen,
                     input logic [4:0] wreg, input logic ld, input logic fl);
    issue_valid   = v;
    issue_rs      = rs;
    issue_rt      = rt;
    issue_use_rs  = urs;
    issue_use_rt  = urt;
    issue_wr_en   = wen;
    issue_wr_reg  = wreg;
    issue_is_load = ld;
    flush         = fl;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
    total++; if (fwd_a !== 2'd0) begin bad++; $display("FAIL reset_fwd_a got=%0d want=0", fwd_a); end
    total++; if (fwd_b !== 2'd0) begin bad++; $display("FAIL reset_fwd_b got=%0d want=0", fwd_b); end
    total++; if (stage_valid !== 3'b000) begin bad++; $display("FAIL reset_stage_valid got=%b want=000", stage_valid); end
    rst = 1'b0;
  endtask

  task automatic test_alu_alu();
    drv(1, 0, 0, 0, 0, 1, 3, 0, 0);          // add r3
    tick();
    drv(1, 3, 0, 1, 0, 1, 1, 0, 0);          // add rs=r3
    @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL alu_stall got=%b want=0", stall); end
    tick();
    idle();
    total++; if (fwd_a !== 2'd1) begin bad++; $display("FAIL alu_fwd_a got=%0d want=1", fwd_a); end
    total++; if (fwd_b !== 2'd0) begin bad++; $display("FAIL alu_fwd_b got=%0d want=0", fwd_b); end
    total++; if (stage_valid !== 3'b011) begin bad++; $display("FAIL alu_stage_valid got=%b want=011", stage_valid); end
    drain();
  endtask

  task automatic test_distance_two();
    drv(1, 0, 0, 0, 0, 1, 5, 0, 0);          // add r5
    tick();
    idle();                                  // nop
    tick();
    drv(1, 0, 5, 0, 1, 1, 6, 0, 0);          // sub rt=r5
    @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL dist2_stall got=%b want=0", stall); end
    tick();
    idle();
    total++; if (fwd_b !== 2'd2) begin bad++; $display("FAIL dist2_fwd_b got=%0d want=2", fwd_b); end
    total++; if (fwd_a !== 2'd0) begin bad++; $display("FAIL dist2_fwd_a got=%0d want=0", fwd_a); end
    drain();
  endtask

  task automatic test_load_use();
    drv(1, 0, 0, 0, 0, 1, 4, 1, 0);          // lw r4
    tick();
    drv(1, 4, 0, 1, 0, 1, 8, 0, 0);          // add rs=r4
    @(negedge clk);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall1 got=%b want=1", stall); end
    tick();
    total++; if (stage_valid !== 3'b010) begin bad++; $display("FAIL lu_bubble got=%b want=010", stage_valid); end
    total++; if (fwd_a !== 2'd0) begin bad++; $display("FAIL lu_fwd_a_held got=%0d want=0", fwd_a); end
    @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_stall2 got=%b want=0", stall); end
    tick();
    idle();
    total++; if (fwd_a !== 2'd2) begin bad++; $display("FAIL lu_fwd_a got=%0d want=2", fwd_a); end
    total++; if (stage_valid !== 3'b101) begin bad++; $display("FAIL lu_stage_valid got=%b want=101", stage_valid); end
    drain();
  endtask

  task automatic test_youngest_r0();
    drv(1, 0, 0, 0, 0, 1, 7, 0, 0);          // add r7
    tick();
    drv(1, 0, 0, 0, 0, 1, 7, 0, 0);          // add r7 again
    tick();
    drv(1, 0, 7, 0, 1, 0, 0, 0, 0);          // use rt=r7
    tick();
    idle();
    total++; if (fwd_b !== 2'd1) begin bad++; $display("FAIL youngest_fwd_b got=%0d want=1", fwd_b); end
    drain();
    drv(1, 0, 0, 0, 0, 1, 0, 1, 0);          // lw r0
    tick();
    drv(1, 0, 0, 1, 1, 1, 9, 0, 0);          // use r0 on both operands
    @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL r0_stall got=%b want=0", stall); end
    tick();
    idle();
    total++; if (fwd_a !== 2'd0) begin bad++; $display("FAIL r0_fwd_a got=%0d want=0", fwd_a); end
    total++; if (fwd_b !== 2'd0) begin bad++; $display("FAIL r0_fwd_b got=%0d want=0", fwd_b); end
    drain();
  endtask

  task automatic test_both_operands();
    drv(1, 0, 0, 0, 0, 1, 8, 0, 0);          // add r8
    tick();
    drv(1, 0, 0, 0, 0, 1, 9, 0, 0);          // add r9
    tick();
    drv(1, 9, 8, 1, 1, 1, 10, 0, 0);         // rs=r9 rt=r8
    tick();
    drv(1, 10, 0, 0, 0, 0, 0, 0, 0);         // reads r10 but use_rs=0
    total++; if (fwd_a !== 2'd1) begin bad++; $display("FAIL both_fwd_a got=%0d want=1", fwd_a); end
    total++; if (fwd_b !== 2'd2) begin bad++; $display("FAIL both_fwd_b got=%0d want=2", fwd_b); end
    tick();
    idle();
    total++; if (fwd_a !== 2'd0) begin bad++; $display("FAIL unused_rs_fwd_a got=%0d want=0", fwd_a); end
    drain();
  endtask

  task automatic test_flush();
    drv(1, 0, 0, 0, 0, 1, 2, 1, 0);          // lw r2
    tick();
    drv(1, 2, 0, 1, 0, 1, 3, 0, 1);          // dependent, flushed
    @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b want=0", stall); end
    tick();
    idle();
    total++; if (fwd_a !== 2'd0) begin bad++; $display("FAIL flush_fwd_a got=%0d want=0", fwd_a); end
    total++; if (stage_valid !== 3'b010) begin bad++; $display("FAIL flush_stage_valid got=%b want=010", stage_valid); end
    drain();
  endtask

  task automatic test_reset_mid_stall();
    drv(1, 0, 0, 0, 0, 1, 6, 1, 0);          // lw r6
    tick();
    drv(1, 6, 0, 1, 0, 1, 11, 0, 0);         // add rs=r6
    @(negedge clk);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL rms_pre_stall got=%b want=1", stall); end
    rst = 1'b1;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rms_forced_stall got=%b want=0", stall); end
    tick();
    total++; if (stage_valid !== 3'b000) begin bad++; $display("FAIL rms_stage_valid got=%b want=000", stage_valid); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rms_post_stall got=%b want=0", stall); end
    tick();
    idle();
    total++; if (fwd_a !== 2'd0) begin bad++; $display("FAIL rms_fwd_a got=%0d want=0", fwd_a); end
    total++; if (stage_valid !== 3'b001) begin bad++; $display("FAIL rms_accept got=%b want=001", stage_valid); end
    drain();
  endtask

`ifdef HAZARD_STATS_EN
  task automatic load_use_seq();
    drv(1, 0, 0, 0, 0, 1, 4, 1, 0);
    tick();
    drv(1, 4, 0, 1, 0, 1, 8, 0, 0);
    tick();                                  // stalled cycle
    tick();                                  // accepted with forwarding
    idle();
    tick();
  endtask

  task automatic test_stats();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL stats_reset got=%0d want=0", stall_cnt); end
    repeat (3) load_use_seq();
    total++; if (stall_cnt !== 32'd3) begin bad++; $display("FAIL stats_stall_cnt got=%0d want=3", stall_cnt); end
    total++; if (fwd_cnt !== 32'd3) begin bad++; $display("FAIL stats_fwd_cnt got=%0d want=3", fwd_cnt); end
    force dut.stall_cnt = 32'hFFFF_FFFF;
    tick();
    release dut.stall_cnt;
    load_use_seq();
    total++; if (stall_cnt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL stats_saturate got=%h want=ffffffff", stall_cnt); end
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_alu_alu();
    test_distance_two();
    test_load_use();
    test_youngest_r0();
    test_both_operands();
    test_flush();
    test_reset_mid_stall();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Parametrised hazard and forwarding unit for the in-order MIPS pipeline.
- Replaces the fixed load-use detector and two-source forwarding pair.
- Keeps an internal scoreboard shift pipeline of in-flight register writers, DEPTH stages deep after issue.
- Produces the issue stall, bubble insertion, and registered per-operand forwarding selects.
- Load latency and pipeline depth are configurable.

Parameters:
- REG_AW, 5, register index width (2**REG_AW architectural registers; register 0 hardwired zero).
- DEPTH, 3, tracked post-issue stages (entry 0 = EX, 1 = MEM, 2 = WB); legal range 2..8.
- LOAD_STAGE, 2, stage index (1..DEPTH-1) where load data first becomes forwardable.
- FW, $clog2(DEPTH), forwarding select width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- issue_valid  in  1  instruction present in ID
- issue_rs  in  REG_AW  source A index
- issue_rt  in  REG_AW  source B index
- issue_use_rs  in  1  instruction reads rs
- issue_use_rt  in  1  instruction reads rt
- issue_wr_en  in  1  instruction writes a register
- issue_wr_reg  in  REG_AW  destination index
- issue_is_load  in  1  destination is produced by a memory read
- flush  in  1  branch/jump taken; kill the instruction in ID
- stall  out  1  combinational; hold PC and IF/ID, inject bubble
- fwd_a  out  FW  registered; source select for operand A during EX (0 = register file, k = stage k result)
- fwd_b  out  FW  same for operand B
- stage_valid  out  DEPTH  registered occupancy of scoreboard entries

Behaviour:
- Scoreboard entry e[j], j = 0..DEPTH-1, holds {v, wr, rd, ld}.
- Each posedge, all entries shift: e[j] <= e[j-1].
- e[0] <= issuing instruction if accept = issue_valid & ~stall & ~flush; otherwise e[0] <= bubble (all fields 0).
- Match(j, r): e[j].v & e[j].wr & (e[j].rd == r) & (r != 0). Only j in 0..DEPTH-2 are considered; an entry at j = DEPTH-1 has committed by the time the issuing instruction reaches EX (register file is write-before-read).
- Operand A is checked only when issue_use_rs; operand B only when issue_use_rt.
- Youngest producer wins: the lowest j with a match decides.
- Hazard: the winning j has e[j].ld = 1 and j+1 < LOAD_STAGE.
  - stall = issue_valid & ~flush & (hazard_a | hazard_b).
  - Default LOAD_STAGE = 2 means only a load in EX stalls, for exactly 1 cycle.
  - In general, a stall lasts LOAD_STAGE-1-j cycles.
- Forward select: when accepted, fwd_a <= winning j+1 (0 if no match); fwd_b likewise. This is valid in the cycle the instruction occupies EX.
- When not accepted (stall, flush, or no issue), fwd_a/fwd_b <= 0.
- flush has priority over stall: a flushed instruction never stalls and enters as a bubble.
- Reset: all entries cleared; fwd_a = fwd_b = 0; stage_valid = 0; stall = 0 for the cycle after reset; stall is forced to 0 while rst is high.
- Reset mid-stall drops the hazard; the held instruction re-evaluates against an empty scoreboard.
- Simultaneous writers to the same rd: the younger entry shadows the older.
- wr = 1 with rd = 0 is tracked but never matches.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined, adds outputs stall_cnt[31:0] and fwd_cnt[31:0]. Both clear on rst.
  - stall_cnt increments on every cycle with stall = 1.
  - fwd_cnt increments once per accepted instruction with fwd_a != 0 or fwd_b != 0 (computed next value).
  - Both saturate at 32'hFFFFFFFF.
- When undefined, the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- ALU-ALU back-to-back: issue add wr r3, then add rs = r3 → next cycle no stall, and fwd_a = 1 the cycle the second instruction is in EX; fwd_b = 0.
- Distance two: add wr r5, nop, sub rt = r5 → fwd_b = 2, no stall.
- Load-use: lw wr r4, then add rs = r4 → stall = 1 for exactly 1 cycle, bubble in e[0] (stage_valid[0] = 0), then accept with fwd_a = 2.
- Youngest wins / r0: add wr r7, add wr r7, use r7 → fwd = 1. Repeating with r0 as destination → fwd = 0, no stall.
- Flush priority: lw wr r2, then dependent instruction with flush = 1 → stall = 0, bubble enters, fwd_a = 0. Reset mid-stall → stall = 0 and stage_valid = 0 next cycle.
- HAZARD_STATS_EN: the load-use sequence above run 3 times → stall_cnt = 3, fwd_cnt = 3. A counter preloaded at FFFFFFFF via force holds after a further stall.
